pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. It generalises the team's fixed 16-bit CLA to any width that is a multiple of 4 and splits the carry chain across a configurable number of register stages. It adds a subtract mode and status flags. It sits between operand-fetch logic and the ALU result mux in the datapath.

## Interface
- WIDTH, 32, operand width; must be a multiple of 4 and ≥ 4
- STAGES, 2, pipeline depth; 1 ≤ STAGES ≤ WIDTH/4; (WIDTH/4) must be divisible by STAGES

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in (add mode only)
- in_sub  in  1  1 = compute A − B, 0 = A + B + in_cin
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of MSB (in sub mode: 1 = no borrow)
- out_ovf  out  1  signed two's-complement overflow
- out_zero  out  1  out_sum == 0

## Operation
- Accept on `in_valid && in_ready`.
- Sub mode: the B operand used is ~in_b and the carry-in used is 1. in_cin is ignored.
- Datapath is built from WIDTH/4 4-bit CLA blocks, each producing group P/G.
- Stage s (0-based) handles blocks s·K … s·K+K−1, where K = WIDTH/(4·STAGES).
  - Within a stage, carries come from second-level lookahead over block P/G.
  - The carry out of a stage is registered and fed to the next stage together with the upper operand slices, which are carried along in pipeline registers.
- Flags:
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_cout = carry out of MSB.
  - out_zero is computed on the final registered sum.
- Global stall: `adv = !out_valid || out_ready`; in_ready = adv. All stage registers, including valid bits, load only when adv = 1.
- Each stage has a valid bit, so bubbles propagate. A stage with valid = 0 may hold stale data, but out_sum, out_cout, out_ovf and out_zero are only meaningful while out_valid = 1.
- Ordering is strictly FIFO. No beat is dropped or duplicated under any out_ready pattern.

## Timing
- Reset, effective at the next edge:
  - All valid bits = 0, so out_valid = 0.
  - out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0.
  - in_ready = 1 in the cycle after reset.
- Latency: a beat accepted at edge n is presented from edge n+STAGES−1 onward. For STAGES = 1, the output register loads at the accepting edge.
- Throughput: one beat per cycle while out_ready = 1.
- When out_valid = 1 and out_ready = 0:
  - in_ready = 0 combinationally, in the same cycle.
  - Outputs hold stable until the handshake completes.
- Simultaneous output handshake and new input in the same cycle: both complete and the pipeline advances.
- If rst = 1 while beats are in flight, all in-flight beats are discarded and none are emitted. rst has priority over the handshake.
- in_ready depends combinationally on out_ready (one-gate path). No other input-to-output combinational paths.

## Structure
- Shared header `cla_defs.vh` holds:
  - the block size constant (4);
  - the parameter-legality check macro: WIDTH%4 == 0 and (WIDTH/4)%STAGES == 0. Elaboration fails with `$error` if the check does not hold.
- One sub-module, `cla4_block`: 4-bit CLA with inputs a, b, cin and outputs sum, P, G. It is instantiated WIDTH/4 times via generate.
- The top handles lookahead across blocks, stage registers, the valid chain, the stall logic and the flags. Target size is 150–300 lines.

## Test plan
All scenarios use WIDTH = 32, STAGES = 2 unless noted.
- Reset: hold rst for 2 cycles with in_valid = 1 → out_valid = 0 and out_sum = 0 throughout; in_ready = 1 after release.
- Add wrap: A = 0xFFFFFFFF, B = 0x00000001, cin = 0 → sum 0x00000000, cout = 1, zero = 1, ovf = 0; out_valid rises 1 cycle after acceptance.
- Cross-stage carry: A = 0x0000FFFF, B = 0x00000001 → 0x00010000, cout = 0. Also A = 0x7FFFFFFF, B = 1 → 0x80000000, ovf = 1.
- Subtract:
  - 5 − 7 → 0xFFFFFFFE, cout = 0, ovf = 0.
  - 0x80000000 − 1 → 0x7FFFFFFF, ovf = 1, cout = 1.
  - in_cin = 1 has no effect in either case.
- Backpressure: send 4 back-to-back beats (1+1, 2+2, 3+3, 4+4) and hold out_ready = 0 for 3 cycles → in_ready drops; results 2, 4, 6, 8 emerge in order, none lost or duplicated.
- Mid-flight reset with 2 beats in flight: assert rst for 1 cycle → out_valid = 0 next cycle and neither result ever appears. Repeat the suite with STAGES = 1 and STAGES = 8, and with WIDTH = 16.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Holds the block size, the parameter-legality rule and the group-carry lookahead.
package pipelined_cla_adder_pkg;

  localparam int CLA_BLK_W  = 4;
  localparam int MAX_BLOCKS = 64;

  function automatic bit cfg_legal(input int width, input int stages);
    return (width >= CLA_BLK_W) && (width % CLA_BLK_W == 0) && (stages >= 1) &&
           ((width / CLA_BLK_W) % stages == 0) &&
           ((width / CLA_BLK_W) / stages <= MAX_BLOCKS);
  endfunction

  // Carry into block k of a stage, expressed as group generate/propagate over blocks 0..k-1.
  function automatic logic group_carry(input logic [MAX_BLOCKS-1:0] p,
                                       input logic [MAX_BLOCKS-1:0] g,
                                       input logic                  cin,
                                       input int                    k);
    logic gg;
    logic pp;
    gg = 1'b0;
    pp = 1'b1;
    for (int j = 0; j < MAX_BLOCKS; j++) begin
      if (j < k) begin
        gg = g[j] | (p[j] & gg);
        pp = pp & p[j];
      end
    end
    return gg | (pp & cin);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla4.sv
// 4-bit carry-lookahead block: sum plus group propagate/generate for the next lookahead level.
module cla4_block
  import pipelined_cla_adder_pkg::*;
(
  input  logic [CLA_BLK_W-1:0] a,
  input  logic [CLA_BLK_W-1:0] b,
  input  logic                 cin,
  output logic [CLA_BLK_W-1:0] sum,
  output logic                 p,
  output logic                 g
);

  logic [CLA_BLK_W-1:0] pb;
  logic [CLA_BLK_W-1:0] gb;
  logic [CLA_BLK_W-1:0] c;

  assign pb = a ^ b;
  assign gb = a & b;

  assign c[0] = cin;
  assign c[1] = gb[0] | (pb[0] & cin);
  assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
  assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0]) |
                (pb[2] & pb[1] & pb[0] & cin);

  assign sum = pb ^ c;
  assign p   = &pb;
  assign g   = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1]) |
               (pb[3] & pb[2] & pb[1] & gb[0]);

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: the carry chain is cut into STAGES register stages,
// with one global stall signal and a valid bit per stage.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NBLK = WIDTH / CLA_BLK_W;
  localparam int K    = NBLK / STAGES;
  localparam int SW   = K * CLA_BLK_W;
  localparam int L    = STAGES - 1;

  if (!cfg_legal(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipelined_cla_adder: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end

  logic adv;

  // Stage inputs (from ports or the previous stage register) and stage results.
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  r_in [STAGES];
  logic              c_in [STAGES];
  logic [WIDTH-1:0]  r_d  [STAGES];
  logic              c_d  [STAGES];
  logic [STAGES-1:0] vld_d;

  // Inter-stage registers; the last stage lands in the output registers instead.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic              c_q [STAGES];
  logic [STAGES-1:0] vld_q;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             ovf_d;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [K-1:0]  bp;
    logic [K-1:0]  bg;
    logic [K:0]    bc;
    logic [SW-1:0] bsum;

    if (s == 0) begin : g_head
      // Subtract is A + ~B + 1; in_cin only matters in add mode.
      assign a_in[s]  = in_a;
      assign b_in[s]  = in_sub ? ~in_b : in_b;
      assign c_in[s]  = in_sub | in_cin;
      assign r_in[s]  = '0;
      assign vld_d[s] = in_valid;
    end else begin : g_body
      assign a_in[s]  = a_q[s-1];
      assign b_in[s]  = b_q[s-1];
      assign c_in[s]  = c_q[s-1];
      assign r_in[s]  = r_q[s-1];
      assign vld_d[s] = vld_q[s-1];
    end

    for (genvar k = 0; k <= K; k++) begin : g_carry
      assign bc[k] = group_carry(MAX_BLOCKS'(bp), MAX_BLOCKS'(bg), c_in[s], k);
    end

    for (genvar k = 0; k < K; k++) begin : g_blk
      localparam int BIT = (s * K + k) * CLA_BLK_W;
      cla4_block u_blk (
        .a   (a_in[s][BIT +: CLA_BLK_W]),
        .b   (b_in[s][BIT +: CLA_BLK_W]),
        .cin (bc[k]),
        .sum (bsum[k*CLA_BLK_W +: CLA_BLK_W]),
        .p   (bp[k]),
        .g   (bg[k])
      );
    end

    assign c_d[s] = bc[K];
    assign r_d[s] = (r_in[s] & ~(WIDTH'({SW{1'b1}}) << (s * SW))) | (WIDTH'(bsum) << (s * SW));
  end

  // Carry into the MSB is recovered from the MSB sum bit: c = a ^ b ^ s.
  assign ovf_d = (a_in[L][WIDTH-1] ^ b_in[L][WIDTH-1] ^ r_d[L][WIDTH-1]) ^ c_d[L];

  assign adv      = !vld_q[L] || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end

  // Stage boundaries: operands ride along with the partial sum and stage carry.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int s = 0; s < L; s++) begin
        if (vld_d[s]) begin
          a_q[s] <= a_in[s];
          b_q[s] <= b_in[s];
          r_q[s] <= r_d[s];
          c_q[s] <= c_d[s];
        end
      end
    end
  end

  // Output stage boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv && vld_d[L]) begin
      sum_q  <= r_d[L];
      cout_q <= c_d[L];
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = vld_q[L];
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = vld_q[L] & ~|sum_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder against a plain-arithmetic reference model.
module tb_pipelined_cla_adder;

  parameter int WIDTH  = 32;
  parameter int STAGES = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  res_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] ALL1, ONE, HALF, MAXPOS, MINNEG;

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci, input logic sb);
    res_t           r;
    logic [WIDTH:0] full;
    if (sb) begin
      r.sum  = a - b;
      r.cout = (a >= b);
      r.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
      r.sum  = full[WIDTH-1:0];
      r.cout = full[WIDTH];
      r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    end
    r.zero = (r.sum == '0);
    return r;
  endfunction

  // One clock cycle: drive, sample mid-cycle, update scoreboard, advance past the edge.
  task automatic cyc(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic ci, input logic sb, input logic ordy,
                     output logic fire, output logic spur, output res_t got, output res_t exp,
                     output logic ov, output logic ir);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = ci;
    in_sub    = sb;
    out_ready = ordy;
    #1;
    ov   = out_valid;
    ir   = in_ready;
    got  = {out_sum, out_cout, out_ovf, out_zero};
    fire = ov && ordy;
    spur = 1'b0;
    exp  = '0;
    if (fire) begin
      if (q.size() > 0) exp = q.pop_front();
      else spur = 1'b1;
    end
    if (v && ir) q.push_back(model(a, b, ci, sb));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic f, sp, ov, ir;
    res_t g, e;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, WIDTH'($urandom()), WIDTH'($urandom()), 1'b1, 1'b0, 1'b0, f, sp, g, e, ov, ir);
      checks++;
      if (ov !== 1'b0 || g !== '0) begin
        errors++;
        $display("FAIL reset_state cyc%0d got valid=%b res=%h want valid=0 res=0", i, ov, g);
      end
    end
    rst = 1'b0;
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, f, sp, g, e, ov, ir);
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got valid=%b ready=%b want valid=0 ready=1", ov, ir);
    end
    q.delete();
  endtask

  task automatic test_add_wrap();
    logic f, sp, ov, ir;
    res_t g, e;
    int   lat;
    lat = -1;
    cyc(1'b1, ALL1, ONE, 1'b0, 1'b0, 1'b1, f, sp, g, e, ov, ir);
    for (int t = 1; t <= STAGES + 4 && lat < 0; t++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, f, sp, g, e, ov, ir);
      if (f) begin
        lat = t;
        checks++;
        if (sp || g !== {{WIDTH{1'b0}}, 1'b1, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL add_wrap got=%h want sum=0 cout=1 ovf=0 zero=1", g);
        end
      end
    end
    checks++;
    if (lat != STAGES) begin
      errors++;
      $display("FAIL add_wrap_latency got %0d cycles want %0d", lat, STAGES);
    end
  endtask

  task automatic test_cross_stage();
    logic f, sp, ov, ir;
    res_t g, e;
    logic [WIDTH-1:0] va[4], vb[4];
    logic vc[4];
    va = '{HALF, MAXPOS, HALF, ALL1 >> 4};
    vb = '{ONE, ONE, '0, ONE};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4 + STAGES + 3; i++) begin
      if (i < 4) cyc(1'b1, va[i], vb[i], vc[i], 1'b0, 1'b1, f, sp, g, e, ov, ir);
      else       cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, f, sp, g, e, ov, ir);
      if (f) begin
        checks++;
        if (sp || g !== e) begin
          errors++;
          $display("FAIL cross_stage got=%h want=%h spurious=%b", g, e, sp);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL cross_stage_drain got %0d pending want 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_subtract();
    logic f, sp, ov, ir;
    res_t g, e;
    logic [WIDTH-1:0] va[5], vb[5];
    logic vc[5];
    va = '{WIDTH'(5), WIDTH'(5), MINNEG, MINNEG, '0};
    vb = '{WIDTH'(7), WIDTH'(7), ONE, ONE, '0};
    vc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5 + STAGES + 3; i++) begin
      if (i < 5) cyc(1'b1, va[i], vb[i], vc[i], 1'b1, 1'b1, f, sp, g, e, ov, ir);
      else       cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, f, sp, g, e, ov, ir);
      if (f) begin
        checks++;
        if (sp || g !== e) begin
          errors++;
          $display("FAIL subtract got=%h want=%h spurious=%b", g, e, sp);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL subtract_drain got %0d pending want 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_backpressure();
    logic f, sp, ov, ir, ordy, prev_ov;
    res_t g, e;
    int   idx, nout, stall, drops;
    idx = 0; nout = 0; stall = -1; drops = 0; prev_ov = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (prev_ov && stall < 0) stall = 0;
      ordy = !(stall >= 1 && stall <= 3);
      cyc(idx < 4, WIDTH'(idx + 1), WIDTH'(idx + 1), 1'b0, 1'b0, ordy, f, sp, g, e, ov, ir);
      if (idx < 4 && ir) idx++;
      if (stall >= 0) stall++;
      prev_ov = ov;
      checks++;
      if (ir !== (!ov || ordy)) begin
        errors++;
        $display("FAIL bp_in_ready got %b want %b", ir, !ov || ordy);
      end
      if (!ir) drops++;
      if (f) begin
        checks++;
        if (sp || g !== e || g.sum !== WIDTH'(2 * (nout + 1))) begin
          errors++;
          $display("FAIL bp_order beat%0d got sum=%h want %h", nout, g.sum, WIDTH'(2 * (nout + 1)));
        end
        nout++;
      end
    end
    checks++;
    if (nout != 4 || drops == 0) begin
      errors++;
      $display("FAIL bp_count got %0d beats %0d stalled cycles want 4 beats and stall", nout, drops);
    end
    q.delete();
  endtask

  task automatic test_midflight_reset();
    logic f, sp, ov, ir;
    res_t g, e;
    int   seen;
    cyc(1'b1, WIDTH'(11), WIDTH'(22), 1'b0, 1'b0, 1'b0, f, sp, g, e, ov, ir);
    cyc(1'b1, WIDTH'(33), WIDTH'(44), 1'b0, 1'b0, 1'b0, f, sp, g, e, ov, ir);
    rst = 1'b1;
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, f, sp, g, e, ov, ir);
    rst = 1'b0;
    q.delete();
    seen = 0;
    for (int t = 0; t < 2 * STAGES + 4; t++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, f, sp, g, e, ov, ir);
      checks++;
      if (ov !== 1'b0) begin
        errors++;
        seen++;
        $display("FAIL midflight_reset cyc%0d got valid=%b sum=%h want valid=0", t, ov, g.sum);
      end
    end
    checks++;
    if (ir !== 1'b1) begin
      errors++;
      $display("FAIL midflight_ready got %b want 1", ir);
    end
  endtask

  task automatic test_random();
    logic f, sp, ov, ir, ordy, v, prev_stall;
    res_t g, e, prev_g;
    logic [WIDTH-1:0] a, b;
    prev_stall = 1'b0;
    prev_g = '0;
    for (int t = 0; t < 400; t++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      a    = WIDTH'({$urandom(), $urandom(), $urandom(), $urandom()});
      b    = WIDTH'({$urandom(), $urandom(), $urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) != 0) ? ALL1 : MINNEG;
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) != 0) ? a : MAXPOS;
      cyc(v, a, b, 1'($urandom()), 1'($urandom()), ordy, f, sp, g, e, ov, ir);
      checks++;
      if (ir !== (!ov || ordy)) begin
        errors++;
        $display("FAIL rand_in_ready t=%0d got %b want %b", t, ir, !ov || ordy);
      end
      if (prev_stall) begin
        checks++;
        if (ov !== 1'b1 || g !== prev_g) begin
          errors++;
          $display("FAIL rand_hold t=%0d got valid=%b res=%h want 1 %h", t, ov, g, prev_g);
        end
      end
      if (f) begin
        checks++;
        if (sp || g !== e) begin
          errors++;
          $display("FAIL rand_result t=%0d got=%h want=%h spurious=%b", t, g, e, sp);
        end
      end
      prev_stall = ov && !ordy;
      prev_g     = g;
    end
    for (int t = 0; t < STAGES + 4; t++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, f, sp, g, e, ov, ir);
      if (f) begin
        checks++;
        if (sp || g !== e) begin
          errors++;
          $display("FAIL rand_drain got=%h want=%h spurious=%b", g, e, sp);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rand_lost got %0d pending want 0", q.size());
    end
    q.delete();
  endtask

  initial begin
    ALL1      = '1;
    ONE       = WIDTH'(1);
    HALF      = ALL1 >> (WIDTH / 2);
    MAXPOS    = ALL1 >> 1;
    MINNEG    = ~MAXPOS;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_add_wrap();
    test_cross_stage();
    test_subtract();
    test_backpressure();
    test_midflight_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
